// File: rtl/bankp_irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bankp_irq_pkg
//  Description : Shared types and constants for the interrupt priority
//                encoder: handshake state enum, request/code widths, the
//                default vector base, and the priority-encode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bankp_irq_pkg;

    localparam int         NUM_REQ       = 8;
    localparam int         CODE_W        = 3;
    localparam logic [7:0] VEC_BASE_DFLT = 8'hE0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } irq_state_t;

    // Index of the highest set bit; bit NUM_REQ-1 has top priority.
    // Returns 0 for an all-zero input (callers qualify with |vec).
    function automatic logic [CODE_W-1:0] prio_encode(input logic [NUM_REQ-1:0] vec);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fall_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fall_det
//  Description : Per-bit 2-flop synchroniser plus history flop, producing a
//                one-cycle pulse on each falling edge of an asynchronous
//                active-low input. All flops reset to 1 so a line held low
//                through reset is seen as exactly one fall after release.
//  Ports       : clk       - system clock
//                rst       - asynchronous active-high reset
//                i_async_n - asynchronous active-low inputs
//                o_fall    - one-cycle fall pulse per bit
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fall_det #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async_n,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_hist  <= '1;
        end else begin
            r_sync1 <= i_async_n;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Previously high, now low: a request edge.
    assign o_fall = r_hist & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/irq_prio_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_encoder
//  Description : Registered 8-to-3 priority encoder with Z80 IM2-style
//                interrupt handshake. Request edges are latched as pending
//                bits; the highest pending source drives int_n and, on
//                acknowledge, is captured into the vector and cleared.
//  Ports       : clk       - system clock
//                reset     - asynchronous active-high reset
//                req_n     - async active-low requests, bit 7 highest
//                ei_n      - active-low encoder enable
//                ack       - CPU interrupt acknowledge level
//                clr_all   - synchronous clear of all pending bits
//                int_n     - active-low interrupt to CPU (registered)
//                gs_n      - active-low "something pending" (registered)
//                code      - index of highest pending request (registered)
//                vector    - VEC_BASE | (acked code << 1) (registered)
//                vec_valid - high while vector holds an acknowledged code
//                pending   - pending-bit register
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_encoder
    import bankp_irq_pkg::*;
#(
    parameter int         NUM_REQ  = bankp_irq_pkg::NUM_REQ,   // fixed at 8
    parameter logic [7:0] VEC_BASE = bankp_irq_pkg::VEC_BASE_DFLT // low nibble must be 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_n,
    input  logic               ei_n,
    input  logic               ack,
    input  logic               clr_all,
    output logic               int_n,
    output logic               gs_n,
    output logic [CODE_W-1:0]  code,
    output logic [7:0]         vector,
    output logic               vec_valid,
    output logic [NUM_REQ-1:0] pending
);

    logic [NUM_REQ-1:0] w_fall;
    logic [NUM_REQ-1:0] w_clr_mask;
    logic [NUM_REQ-1:0] w_pend_next;
    logic [CODE_W-1:0]  w_code_now;
    logic               w_capture;
    irq_state_t         w_state_next;

    logic [NUM_REQ-1:0] r_pending;
    irq_state_t         r_state;
    logic               r_int_n;
    logic               r_gs_n;
    logic [CODE_W-1:0]  r_code;
    logic [7:0]         r_vector;
    logic               r_vec_valid;

    sync_fall_det #(
        .WIDTH (NUM_REQ)
    ) u_sync_fall_det (
        .clk       (clk),
        .rst       (reset),
        .i_async_n (req_n),
        .o_fall    (w_fall)
    );

    // Combinational encode of the current pending set; this is what an
    // acknowledge captures, so a late higher-priority edge is honoured.
    assign w_code_now = prio_encode(r_pending);

    // Handshake next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if ((|r_pending) && !ei_n) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                // Losing enable or the pending set wins over a coincident ack.
                if (ei_n || (r_pending == '0)) begin
                    w_state_next = IDLE;
                end else if (ack) begin
                    w_state_next = ACK;
                    w_capture    = 1'b1;
                end
            end
            ACK: begin
                // ack held high stays here: no second capture.
                if (!ack) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pending update: clears first, then new edges OR'd in so a fresh
    // request on the same bit survives its own acknowledge or clr_all.
    always_comb begin
        w_clr_mask = '0;
        if (clr_all) begin
            w_clr_mask = '1;
        end
        if (w_capture) begin
            w_clr_mask[w_code_now] = 1'b1;
        end
        w_pend_next = (r_pending & ~w_clr_mask) | w_fall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending   <= '0;
            r_int_n     <= 1'b1;
            r_gs_n      <= 1'b1;
            r_code      <= '0;
            r_vector    <= VEC_BASE;
            r_vec_valid <= 1'b0;
        end else begin
            r_pending   <= w_pend_next;
            r_int_n     <= (w_state_next != REQ);
            r_gs_n      <= ~(|r_pending);
            r_code      <= w_code_now;
            r_vec_valid <= (w_state_next == ACK);
            if (w_capture) begin
                r_vector <= VEC_BASE | {{(7 - CODE_W){1'b0}}, w_code_now, 1'b0};
            end
        end
    end

    assign int_n     = r_int_n;
    assign gs_n      = r_gs_n;
    assign code      = r_code;
    assign vector    = r_vector;
    assign vec_valid = r_vec_valid;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_irq_prio_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_prio_encoder
//  Description : Directed self-checking bench for irq_prio_encoder.
//                Inputs change 1ns after a rising edge; outputs are sampled
//                at the same point, i.e. reflecting the edge just taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_prio_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] req_n;
    logic       ei_n;
    logic       ack;
    logic       clr_all;
    logic       int_n;
    logic       gs_n;
    logic [2:0] code;
    logic [7:0] vector;
    logic       vec_valid;
    logic [7:0] pending;

    int n_vec;
    int n_err;

    irq_prio_encoder #(
        .NUM_REQ  (8),
        .VEC_BASE (8'hE0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_n     (req_n),
        .ei_n      (ei_n),
        .ack       (ack),
        .clr_all   (clr_all),
        .int_n     (int_n),
        .gs_n      (gs_n),
        .code      (code),
        .vector    (vector),
        .vec_valid (vec_valid),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        req_n   = 8'hFF;
        ei_n    = 1'b0;
        ack     = 1'b0;
        clr_all = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_int_n",   {7'd0, int_n},     8'h01);
        chk("rst_gs_n",    {7'd0, gs_n},      8'h01);
        chk("rst_code",    {5'd0, code},      8'h00);
        chk("rst_vector",  vector,            8'hE0);
        chk("rst_vvalid",  {7'd0, vec_valid}, 8'h00);
        chk("rst_pending", pending,           8'h00);
        reset = 1'b0;
        tick(); tick();

        // T1: single request on bit 5, latency and full handshake
        req_n = 8'hDF;
        tick(); tick();
        chk("t1_pend_k1",  pending,           8'h00);
        tick();
        chk("t1_pend_k2",  pending,           8'h20);
        chk("t1_int_k2",   {7'd0, int_n},     8'h01);
        tick();
        chk("t1_int_k3",   {7'd0, int_n},     8'h00);
        chk("t1_code_k3",  {5'd0, code},      8'h05);
        chk("t1_gs_k3",    {7'd0, gs_n},      8'h00);
        req_n = 8'hFF;
        ack   = 1'b1;
        tick();
        chk("t1_vector",   vector,            8'hEA);
        chk("t1_vvalid",   {7'd0, vec_valid}, 8'h01);
        chk("t1_pend_ack", pending,           8'h00);
        chk("t1_int_ack",  {7'd0, int_n},     8'h01);
        ack = 1'b0;
        tick();
        chk("t1_vv_rel",   {7'd0, vec_valid}, 8'h00);
        chk("t1_vec_hold", vector,            8'hEA);
        tick();
        chk("t1_int_idle", {7'd0, int_n},     8'h01);
        chk("t1_gs_idle",  {7'd0, gs_n},      8'h01);

        // T2: simultaneous falls on bits 6 and 1, served highest first
        req_n = 8'hBD;
        tick(); tick(); tick();
        chk("t2_pend",     pending,           8'h42);
        tick();
        chk("t2_int",      {7'd0, int_n},     8'h00);
        chk("t2_code6",    {5'd0, code},      8'h06);
        req_n = 8'hFF;
        ack   = 1'b1;
        tick();
        chk("t2_vec1",     vector,            8'hEC);
        chk("t2_pend1",    pending,           8'h02);
        ack = 1'b0;
        tick();
        chk("t2_int_rel",  {7'd0, int_n},     8'h01);
        tick();
        chk("t2_int_re",   {7'd0, int_n},     8'h00);
        chk("t2_code1",    {5'd0, code},      8'h01);
        ack = 1'b1;
        tick();
        chk("t2_vec2",     vector,            8'hE2);
        chk("t2_pend2",    pending,           8'h00);
        ack = 1'b0;
        tick(); tick();

        // T3: enable gating
        ei_n  = 1'b1;
        req_n = 8'hF7;
        tick(); tick(); tick();
        chk("t3_pend",     pending,           8'h08);
        tick();
        chk("t3_gs",       {7'd0, gs_n},      8'h00);
        chk("t3_int_dis",  {7'd0, int_n},     8'h01);
        req_n = 8'hFF;
        tick();
        chk("t3_int_dis2", {7'd0, int_n},     8'h01);
        ei_n = 1'b0;
        tick();
        chk("t3_int_en",   {7'd0, int_n},     8'h00);
        ack = 1'b1;
        tick();
        chk("t3_vec",      vector,            8'hE6);
        ack = 1'b0;
        tick(); tick();

        // T4: new fall on bit 2 coincident with its ack capture
        req_n = 8'hFB;
        tick(); tick(); tick();
        chk("t4_pend",     pending,           8'h04);
        tick();
        chk("t4_int",      {7'd0, int_n},     8'h00);
        req_n = 8'hFF;
        tick(); tick(); tick();
        req_n = 8'hFB;
        tick(); tick();
        ack = 1'b1;
        tick();
        chk("t4_set_wins", pending,           8'h04);
        chk("t4_vec",      vector,            8'hE4);
        chk("t4_vvalid",   {7'd0, vec_valid}, 8'h01);
        req_n = 8'hFF;
        ack   = 1'b0;
        tick();
        chk("t4_int_rel",  {7'd0, int_n},     8'h01);
        tick();
        chk("t4_int_re",   {7'd0, int_n},     8'h00);
        ack = 1'b1;
        tick();
        chk("t4_pend_clr", pending,           8'h00);
        ack = 1'b0;
        tick(); tick();

        // T5: clr_all while in REQ, subsequent ack ignored
        req_n = 8'hEF;
        tick(); tick(); tick();
        tick();
        chk("t5_int",      {7'd0, int_n},     8'h00);
        req_n   = 8'hFF;
        clr_all = 1'b1;
        tick();
        chk("t5_pend_clr", pending,           8'h00);
        clr_all = 1'b0;
        tick();
        chk("t5_gs",       {7'd0, gs_n},      8'h01);
        chk("t5_int_idle", {7'd0, int_n},     8'h01);
        ack = 1'b1;
        tick(); tick();
        chk("t5_vv_ign",   {7'd0, vec_valid}, 8'h00);
        chk("t5_int_ign",  {7'd0, int_n},     8'h01);
        chk("t5_vec_hold", vector,            8'hE4);
        ack = 1'b0;
        tick();

        // T6: reset in ACK, request held low across reset
        req_n = 8'h7F;
        tick(); tick(); tick();
        tick();
        chk("t6_int",      {7'd0, int_n},     8'h00);
        req_n = 8'hFF;
        ack   = 1'b1;
        tick();
        chk("t6_vvalid",   {7'd0, vec_valid}, 8'h01);
        chk("t6_vec",      vector,            8'hEE);
        req_n = 8'hFE;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_r_vvalid", {7'd0, vec_valid}, 8'h00);
        chk("t6_r_vec",    vector,            8'hE0);
        chk("t6_r_int",    {7'd0, int_n},     8'h01);
        chk("t6_r_pend",   pending,           8'h00);
        chk("t6_r_gs",     {7'd0, gs_n},      8'h01);
        ack = 1'b0;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk("t6_pend0",    pending,           8'h01);
        tick();
        chk("t6_int0",     {7'd0, int_n},     8'h00);
        chk("t6_code0",    {5'd0, code},      8'h00);
        chk("t6_gs0",      {7'd0, gs_n},      8'h00);
        req_n = 8'hFF;
        ack   = 1'b1;
        tick();
        chk("t6_vec0",     vector,            8'hE0);
        chk("t6_vv0",      {7'd0, vec_valid}, 8'h01);
        chk("t6_pend_end", pending,           8'h00);
        ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
